// File: rtl/e_mult_div_unit_if.sv
// Handshake bundle between the E stage / stall controller and the multiply/divide unit.
// Start/E_MDOut are combinational from the unit; Busy, HI and LO are registered.
interface e_mult_div_unit_if;
    logic [3:0]  E_MDControl;
    logic [31:0] E_RS;
    logic [31:0] E_RT;
    logic        Start;
    logic        Busy;
    logic [31:0] E_MDOut;
    logic [31:0] HI;
    logic [31:0] LO;

    // Handshake: an op is accepted on the rising edge where Start=1 (op is Start-class and unit IDLE);
    // Busy then stays high for exactly N cycles and the upstream must not present Start-class ops meanwhile.
    modport master (
        output E_MDControl, E_RS, E_RT,
        input  Start, Busy, E_MDOut, HI, LO
    );

    modport slave (
        input  E_MDControl, E_RS, E_RT,
        output Start, Busy, E_MDOut, HI, LO
    );
endinterface

// File: rtl/e_mult_div_unit.sv
// E-stage multiply/divide unit owning HI/LO; fixed-latency mult/div, single-cycle mfhi/mflo/mthi/mtlo.
// Optional madd/maddu/msub/msubu (codes 9-12) are compiled in when MDU_MADD_EN is defined.
module e_mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    e_mult_div_unit_if.slave     md,
    output logic [0:0]           state_dbg
);
    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_e           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [31:0]      hi, lo, tmp_hi, tmp_lo;
    logic             tmp_keep;
    logic             start;

    logic             op_start, op_signed, op_div;
`ifdef MDU_MADD_EN
    logic             op_acc, op_sub;
`endif

    always_comb begin
        op_start  = 1'b0;
        op_signed = 1'b0;
        op_div    = 1'b0;
`ifdef MDU_MADD_EN
        op_acc    = 1'b0;
        op_sub    = 1'b0;
`endif
        case (md.E_MDControl)
            4'd1: begin op_start = 1'b1; op_signed = 1'b1; end
            4'd2: begin op_start = 1'b1; end
            4'd3: begin op_start = 1'b1; op_signed = 1'b1; op_div = 1'b1; end
            4'd4: begin op_start = 1'b1; op_div = 1'b1; end
`ifdef MDU_MADD_EN
            4'd9:  begin op_start = 1'b1; op_signed = 1'b1; op_acc = 1'b1; end
            4'd10: begin op_start = 1'b1; op_acc = 1'b1; end
            4'd11: begin op_start = 1'b1; op_signed = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
            4'd12: begin op_start = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
`endif
            default: ;
        endcase
    end

    // Signed ops run on magnitudes through one unsigned multiplier/divider, signs fixed afterwards.
    // |0x80000000| stays 0x80000000 unsigned, so the INT_MIN / -1 case needs no special path.
    logic [31:0] mag_rs, mag_rt, dvs_safe, uq, ur, quo, rem;
    logic [63:0] umag, prod, result;
    logic        neg_res, div_zero;

    always_comb begin
        mag_rs   = (op_signed && md.E_RS[31]) ? -md.E_RS : md.E_RS;
        mag_rt   = (op_signed && md.E_RT[31]) ? -md.E_RT : md.E_RT;
        neg_res  = op_signed && (md.E_RS[31] ^ md.E_RT[31]);
        dvs_safe = (mag_rt == 32'd0) ? 32'd1 : mag_rt;
        umag     = {32'd0, mag_rs} * {32'd0, mag_rt};
        prod     = neg_res ? -umag : umag;
        uq       = mag_rs / dvs_safe;
        ur       = mag_rs % dvs_safe;
        quo      = neg_res ? -uq : uq;
        rem      = (op_signed && md.E_RS[31]) ? -ur : ur;
        div_zero = op_div && (md.E_RT == 32'd0);
        result   = op_div ? {rem, quo} : prod;
`ifdef MDU_MADD_EN
        if (op_acc) begin
            result = op_sub ? ({hi, lo} - prod) : ({hi, lo} + prod);
        end
`endif
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        start      = 1'b0;
        case (state)
            S_IDLE: begin
                if (op_start) begin
                    start      = 1'b1;
                    state_next = S_RUN;
                    cnt_next   = op_div ? DIV_LOAD : MULT_LOAD;
                end
            end
            S_RUN: begin
                if (cnt == '0) begin
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            tmp_hi   <= 32'd0;
            tmp_lo   <= 32'd0;
            tmp_keep <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (start) begin
                tmp_hi   <= result[63:32];
                tmp_lo   <= result[31:0];
                tmp_keep <= div_zero;
            end
            // Divide-by-zero still spends the full busy period but leaves HI/LO untouched.
            if (state == S_RUN && cnt == '0 && !tmp_keep) begin
                hi <= tmp_hi;
                lo <= tmp_lo;
            end else if (state == S_IDLE && md.E_MDControl == 4'd7) begin
                hi <= md.E_RS;
            end else if (state == S_IDLE && md.E_MDControl == 4'd8) begin
                lo <= md.E_RS;
            end
        end
    end

    assign md.Start   = start;
    assign md.Busy    = (state == S_RUN);
    assign md.HI      = hi;
    assign md.LO      = lo;
    assign md.E_MDOut = (md.E_MDControl == 4'd5) ? hi :
                        (md.E_MDControl == 4'd6) ? lo : 32'd0;
    assign state_dbg  = state;
endmodule
